// File: rtl/fpu_addsub_unpack_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_addsub_unpack_if
// Description : Handshake and operand/result bundle for the FADD/FSUB unpack
//               stage. The master side issues operations and consumes the
//               unpacked entry. The slave side is the unpack stage itself.
//   Input side  : in_valid_i/in_ready_o, opA_i, opB_i, sub_op_i, rm_i,
//                 frm_i, tag_i
//   Output side : out_valid_o/out_ready_i, sign/exp/sig per operand, class
//                 flags, isSignaling_o, sub_op_o, rounding_mode_o,
//                 rm_illegal_o, exp_diff_o, swap_o, tag_o
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_addsub_unpack_if #(
  parameter int TAG_W = 5
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      opA_i;
  logic [31:0]      opB_i;
  logic             sub_op_i;
  logic [2:0]       rm_i;
  logic [2:0]       frm_i;
  logic [TAG_W-1:0] tag_i;

  logic             out_valid_o;
  logic             out_ready_i;
  logic             sign_A_o, sign_B_o;
  logic [7:0]       exp_A_o, exp_B_o;
  logic [22:0]      sig_A_o, sig_B_o;
  logic             isZeroA_o, isZeroB_o, isInfA_o, isInfB_o;
  logic             isNaNA_o, isNaNB_o, isSubA_o, isSubB_o;
  logic             isSignaling_o;
  logic             sub_op_o;
  logic [2:0]       rounding_mode_o;
  logic             rm_illegal_o;
  logic [7:0]       exp_diff_o;
  logic             swap_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output in_valid_i, opA_i, opB_i, sub_op_i, rm_i, frm_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, sign_A_o, sign_B_o, exp_A_o, exp_B_o,
           sig_A_o, sig_B_o, isZeroA_o, isZeroB_o, isInfA_o, isInfB_o,
           isNaNA_o, isNaNB_o, isSubA_o, isSubB_o, isSignaling_o, sub_op_o,
           rounding_mode_o, rm_illegal_o, exp_diff_o, swap_o, tag_o
  );

  modport slave (
    input  in_valid_i, opA_i, opB_i, sub_op_i, rm_i, frm_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, sign_A_o, sign_B_o, exp_A_o, exp_B_o,
           sig_A_o, sig_B_o, isZeroA_o, isZeroB_o, isInfA_o, isInfB_o,
           isNaNA_o, isNaNB_o, isSubA_o, isSubB_o, isSignaling_o, sub_op_o,
           rounding_mode_o, rm_illegal_o, exp_diff_o, swap_o, tag_o
  );
endinterface
`default_nettype wire

// File: rtl/fpu_addsub_unpack.sv
`default_nettype none
// ============================================================================
// Module      : fpu_addsub_unpack
// Description : Operand unpack/classify stage ahead of the FADD/FSUB datapath.
//               Splits two binary32 operands into fields, classifies them,
//               resolves the rounding mode and pre-computes the exponent
//               alignment (difference and swap). One cycle of latency, backed
//               by a 2-entry skid buffer so in_ready_o comes from a flop.
// Ports       : clk_i   - clock
//               reset_i - asynchronous active-low reset
//               flush_i - synchronous kill of all held entries
//               bus     - slave side of fpu_addsub_unpack_if
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_addsub_unpack #(
  parameter int TAG_W = 5
) (
  input  wire logic               clk_i,
  input  wire logic               reset_i,
  input  wire logic               flush_i,
  fpu_addsub_unpack_if.slave      bus
);

  typedef struct packed {
    logic             sign_a;
    logic             sign_b;
    logic [7:0]       exp_a;
    logic [7:0]       exp_b;
    logic [22:0]      sig_a;
    logic [22:0]      sig_b;
    logic             zero_a;
    logic             zero_b;
    logic             inf_a;
    logic             inf_b;
    logic             nan_a;
    logic             nan_b;
    logic             sub_a;
    logic             sub_b;
    logic             signaling;
    logic             sub_op;
    logic [2:0]       rm;
    logic             rm_illegal;
    logic [7:0]       exp_diff;
    logic             swap;
    logic [TAG_W-1:0] tag;
  } payload_t;

  localparam logic [2:0] c_RM_DYN = 3'b111;

  payload_t   w_new;
  logic [7:0] w_eff_a;
  logic [7:0] w_eff_b;
  logic       w_accept;
  logic       w_drain;

  payload_t   r_main;
  payload_t   r_skid;
  logic       r_main_valid;
  logic       r_skid_valid;

  // --------------------------------------------------------------------------
  // Unpack / classify the incoming operation
  // --------------------------------------------------------------------------
  always_comb begin
    w_new        = '0;
    w_new.sign_a = bus.opA_i[31];
    w_new.sign_b = bus.opB_i[31];
    w_new.exp_a  = bus.opA_i[30:23];
    w_new.exp_b  = bus.opB_i[30:23];
    w_new.sig_a  = bus.opA_i[22:0];
    w_new.sig_b  = bus.opB_i[22:0];

    w_new.zero_a = (w_new.exp_a == 8'h00) && (w_new.sig_a == '0);
    w_new.sub_a  = (w_new.exp_a == 8'h00) && (w_new.sig_a != '0);
    w_new.inf_a  = (w_new.exp_a == 8'hFF) && (w_new.sig_a == '0);
    w_new.nan_a  = (w_new.exp_a == 8'hFF) && (w_new.sig_a != '0);
    w_new.zero_b = (w_new.exp_b == 8'h00) && (w_new.sig_b == '0);
    w_new.sub_b  = (w_new.exp_b == 8'h00) && (w_new.sig_b != '0);
    w_new.inf_b  = (w_new.exp_b == 8'hFF) && (w_new.sig_b == '0);
    w_new.nan_b  = (w_new.exp_b == 8'hFF) && (w_new.sig_b != '0);

    // A NaN with the quiet bit clear is signaling.
    w_new.signaling = (w_new.nan_a && !w_new.sig_a[22]) ||
                      (w_new.nan_b && !w_new.sig_b[22]);

    w_new.sub_op = bus.sub_op_i;
    w_new.rm     = (bus.rm_i == c_RM_DYN) ? bus.frm_i : bus.rm_i;
    // Reserved encodings still flow through; downstream raises the trap.
    w_new.rm_illegal = (w_new.rm == 3'b101) || (w_new.rm == 3'b110) ||
                       (w_new.rm == 3'b111);

    // Magnitude compare on {exp,frac} orders the operands ignoring sign.
    w_new.swap     = (bus.opB_i[30:0] > bus.opA_i[30:0]);
    w_new.exp_diff = w_new.swap ? (w_eff_b - w_eff_a) : (w_eff_a - w_eff_b);
    w_new.tag      = bus.tag_i;
  end

  // Subnormals share the minimum normal's exponent for alignment.
  assign w_eff_a = (bus.opA_i[30:23] == 8'h00) ? 8'd1 : bus.opA_i[30:23];
  assign w_eff_b = (bus.opB_i[30:23] == 8'h00) ? 8'd1 : bus.opB_i[30:23];

  // --------------------------------------------------------------------------
  // Two-entry skid buffer: r_main drives the outputs, r_skid catches the op
  // accepted while r_main is stalled.
  // --------------------------------------------------------------------------
  assign w_accept = bus.in_valid_i && !r_skid_valid && !flush_i;
  assign w_drain  = r_main_valid && bus.out_ready_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_drain) begin
      // Main slot frees this edge; the older skid entry has priority.
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main       <= w_new;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready_o      = !r_skid_valid;
  assign bus.out_valid_o     = r_main_valid;
  assign bus.sign_A_o        = r_main.sign_a;
  assign bus.sign_B_o        = r_main.sign_b;
  assign bus.exp_A_o         = r_main.exp_a;
  assign bus.exp_B_o         = r_main.exp_b;
  assign bus.sig_A_o         = r_main.sig_a;
  assign bus.sig_B_o         = r_main.sig_b;
  assign bus.isZeroA_o       = r_main.zero_a;
  assign bus.isZeroB_o       = r_main.zero_b;
  assign bus.isInfA_o        = r_main.inf_a;
  assign bus.isInfB_o        = r_main.inf_b;
  assign bus.isNaNA_o        = r_main.nan_a;
  assign bus.isNaNB_o        = r_main.nan_b;
  assign bus.isSubA_o        = r_main.sub_a;
  assign bus.isSubB_o        = r_main.sub_b;
  assign bus.isSignaling_o   = r_main.signaling;
  assign bus.sub_op_o        = r_main.sub_op;
  assign bus.rounding_mode_o = r_main.rm;
  assign bus.rm_illegal_o    = r_main.rm_illegal;
  assign bus.exp_diff_o      = r_main.exp_diff;
  assign bus.swap_o          = r_main.swap;
  assign bus.tag_o           = r_main.tag;

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_addsub_unpack
// Description : Self-checking bench for fpu_addsub_unpack. Directed vector
//               table for the unpack/classify function plus hand-written
//               sequences for back-pressure, streaming, flush and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_addsub_unpack;

  localparam int TAG_W = 5;

  logic clk;
  logic rst_n;
  logic flush;

  int n_checks = 0;
  int n_errors = 0;

  fpu_addsub_unpack_if #(.TAG_W(TAG_W)) u_if ();

  fpu_addsub_unpack #(.TAG_W(TAG_W)) u_dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .flush_i (flush),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags packed as {zA,zB,iA,iB,nA,nB,sA,sB}
  typedef struct {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        sub_op;
    logic [2:0]  rm;
    logic [2:0]  frm;
    logic [4:0]  tag;
    logic [7:0]  exp_flags;
    logic        exp_sig;
    logic [2:0]  exp_rm;
    logic        exp_ill;
    logic [7:0]  exp_diff;
    logic        exp_swap;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [2:0] rm, input logic [2:0] frm, input logic [4:0] tag);
    u_if.in_valid_i = 1'b1;
    u_if.opA_i      = a;
    u_if.opB_i      = b;
    u_if.sub_op_i   = s;
    u_if.rm_i       = rm;
    u_if.frm_i      = frm;
    u_if.tag_i      = tag;
  endtask

  function automatic logic [7:0] dut_flags();
    return {u_if.isZeroA_o, u_if.isZeroB_o, u_if.isInfA_o, u_if.isInfB_o,
            u_if.isNaNA_o, u_if.isNaNB_o, u_if.isSubA_o, u_if.isSubB_o};
  endfunction

  initial begin
    vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 3'b000, 3'b000, 5'd1,
                8'b00000000, 1'b0, 3'b000, 1'b0, 8'd1,   1'b1};
    vecs[1] = '{32'h7F800001, 32'h00000000, 1'b0, 3'b000, 3'b000, 5'd2,
                8'b01001000, 1'b1, 3'b000, 1'b0, 8'd254, 1'b0};
    vecs[2] = '{32'h7FC00000, 32'h00000000, 1'b1, 3'b001, 3'b000, 5'd3,
                8'b01001000, 1'b0, 3'b001, 1'b0, 8'd254, 1'b0};
    vecs[3] = '{32'h00000001, 32'h80800000, 1'b0, 3'b111, 3'b011, 5'd4,
                8'b00000010, 1'b0, 3'b011, 1'b0, 8'd0,   1'b1};
    vecs[4] = '{32'h00000001, 32'h80800000, 1'b0, 3'b111, 3'b110, 5'd5,
                8'b00000010, 1'b0, 3'b110, 1'b1, 8'd0,   1'b1};
    vecs[5] = '{32'hFF800000, 32'h7F800000, 1'b1, 3'b101, 3'b000, 5'd6,
                8'b00110000, 1'b0, 3'b101, 1'b1, 8'd0,   1'b0};
    vecs[6] = '{32'h00400000, 32'h00000000, 1'b0, 3'b010, 3'b000, 5'd7,
                8'b01000010, 1'b0, 3'b010, 1'b0, 8'd0,   1'b0};
    vecs[7] = '{32'h3F800000, 32'hBF000000, 1'b1, 3'b100, 3'b000, 5'd8,
                8'b00000000, 1'b0, 3'b100, 1'b0, 8'd1,   1'b0};
    vecs[8] = '{32'h00000000, 32'h7F800001, 1'b0, 3'b111, 3'b000, 5'd9,
                8'b10000100, 1'b1, 3'b000, 1'b0, 8'd254, 1'b1};
    vecs[9] = '{32'h7FFFFFFF, 32'h7FBFFFFF, 1'b0, 3'b011, 3'b000, 5'd10,
                8'b00001100, 1'b1, 3'b011, 1'b0, 8'd0,   1'b0};
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    u_if.in_valid_i  = 1'b0;
    u_if.opA_i       = '0;
    u_if.opB_i       = '0;
    u_if.sub_op_i    = 1'b0;
    u_if.rm_i        = '0;
    u_if.frm_i       = '0;
    u_if.tag_i       = '0;
    u_if.out_ready_i = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(u_if.out_valid_o), 64'd0);
    chk("reset_in_ready",  64'(u_if.in_ready_o),  64'd1);
    chk("reset_data",      64'({u_if.exp_A_o, u_if.sig_B_o, u_if.tag_o, u_if.swap_o}), 64'd0);
    rst_n = 1'b1;

    // ---------------- table-driven single ops ----------------
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_op(vecs[i].op_a, vecs[i].op_b, vecs[i].sub_op, vecs[i].rm, vecs[i].frm, vecs[i].tag);
      @(negedge clk);
      u_if.in_valid_i = 1'b0;
      chk($sformatf("v%0d_valid", i), 64'(u_if.out_valid_o), 64'd1);
      chk($sformatf("v%0d_fields", i),
          64'({u_if.sign_A_o, u_if.exp_A_o, u_if.sig_A_o}), 64'(vecs[i].op_a));
      chk($sformatf("v%0d_fieldsB", i),
          64'({u_if.sign_B_o, u_if.exp_B_o, u_if.sig_B_o}), 64'(vecs[i].op_b));
      chk($sformatf("v%0d_flags", i), 64'(dut_flags()), 64'(vecs[i].exp_flags));
      chk($sformatf("v%0d_signaling", i), 64'(u_if.isSignaling_o), 64'(vecs[i].exp_sig));
      chk($sformatf("v%0d_rm", i),
          64'({u_if.rounding_mode_o, u_if.rm_illegal_o}), 64'({vecs[i].exp_rm, vecs[i].exp_ill}));
      chk($sformatf("v%0d_align", i),
          64'({u_if.exp_diff_o, u_if.swap_o}), 64'({vecs[i].exp_diff, vecs[i].exp_swap}));
      chk($sformatf("v%0d_tag_sub", i),
          64'({u_if.tag_o, u_if.sub_op_o}), 64'({vecs[i].tag, vecs[i].sub_op}));
    end
    @(negedge clk);
    chk("idle_valid", 64'(u_if.out_valid_o), 64'd0);
    chk("idle_hold_tag", 64'(u_if.tag_o), 64'd10);

    // ---------------- back-pressure ----------------
    u_if.out_ready_i = 1'b0;
    drive_op(32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 3'b000, 5'd1);
    @(negedge clk);
    chk("bp_ready_after1", 64'(u_if.in_ready_o), 64'd1);
    drive_op(32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 3'b000, 5'd2);
    @(negedge clk);
    chk("bp_ready_after2", 64'(u_if.in_ready_o), 64'd0);
    drive_op(32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 3'b000, 5'd3);
    @(negedge clk);
    chk("bp_stall_ready", 64'(u_if.in_ready_o), 64'd0);
    chk("bp_head", 64'({u_if.out_valid_o, u_if.tag_o}), 64'({1'b1, 5'd1}));
    u_if.out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_second", 64'({u_if.out_valid_o, u_if.tag_o}), 64'({1'b1, 5'd2}));
    chk("bp_ready_reopen", 64'(u_if.in_ready_o), 64'd1);
    @(negedge clk);
    u_if.in_valid_i = 1'b0;
    chk("bp_third", 64'({u_if.out_valid_o, u_if.tag_o}), 64'({1'b1, 5'd3}));
    @(negedge clk);
    chk("bp_empty", 64'(u_if.out_valid_o), 64'd0);

    // ---------------- streaming ----------------
    for (int i = 0; i <= 16; i++) begin
      if (i > 0)
        chk($sformatf("stream_out%0d", i - 1),
            64'({u_if.out_valid_o, u_if.tag_o}), 64'({1'b1, 5'(i - 1)}));
      chk($sformatf("stream_ready%0d", i), 64'(u_if.in_ready_o), 64'd1);
      if (i < 16) drive_op(32'h40400000, 32'h3F800000, 1'b0, 3'b000, 3'b000, 5'(i));
      else        u_if.in_valid_i = 1'b0;
      @(negedge clk);
    end
    chk("stream_drained", 64'(u_if.out_valid_o), 64'd0);

    // ---------------- flush ----------------
    u_if.out_ready_i = 1'b0;
    drive_op(32'h3F800000, 32'h40000000, 1'b0, 3'b000, 3'b000, 5'd5);
    @(negedge clk);
    drive_op(32'h3F800000, 32'h40000000, 1'b0, 3'b000, 3'b000, 5'd6);
    @(negedge clk);
    chk("flush_full", 64'({u_if.out_valid_o, u_if.in_ready_o}), 64'({1'b1, 1'b0}));
    drive_op(32'h3F800000, 32'h40000000, 1'b0, 3'b000, 3'b000, 5'd7);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    u_if.in_valid_i = 1'b0;
    chk("flush_cleared", 64'({u_if.out_valid_o, u_if.in_ready_o}), 64'({1'b0, 1'b1}));
    u_if.out_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_ghost", 64'(u_if.out_valid_o), 64'd0);
    end

    // ---------------- async reset mid-stream ----------------
    u_if.out_ready_i = 1'b0;
    drive_op(32'h40000000, 32'h3F800000, 1'b0, 3'b001, 3'b000, 5'd9);
    @(negedge clk);
    drive_op(32'h40000000, 32'h3F800000, 1'b0, 3'b001, 3'b000, 5'd10);
    @(negedge clk);
    u_if.in_valid_i = 1'b0;
    chk("ar_loaded", 64'({u_if.out_valid_o, u_if.tag_o}), 64'({1'b1, 5'd9}));
    #1 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'({u_if.out_valid_o, u_if.in_ready_o}), 64'({1'b0, 1'b1}));
    chk("ar_data_zero",
        64'({u_if.exp_A_o, u_if.tag_o, u_if.rounding_mode_o, u_if.exp_diff_o}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    u_if.out_ready_i = 1'b1;
    @(negedge clk);
    chk("ar_lost", 64'(u_if.out_valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_addsub_unpack.md
Name: fpu_addsub_unpack

Overview:
Operand unpack/classify pipeline stage directly upstream of the FADD/FSUB fast-path and main-path datapath. Accepts two raw binary32 operands with op/rounding info over a valid/ready handshake. Produces registered fields, class flags, the signaling indicator, the resolved rounding mode and alignment pre-computation, one cycle later. A 2-entry skid buffer keeps in_ready_o registered.

Parameters:
TAG_W, 5, width of opaque tag (destination reg) carried with each operation

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous kill of all held entries
in_valid_i  in  1  input operation valid
in_ready_o  out  1  stage can accept
opA_i  in  32  operand A, binary32
opB_i  in  32  operand B, binary32
sub_op_i  in  1  1 = FSUB
rm_i  in  3  instruction rounding mode
frm_i  in  3  fcsr dynamic rounding mode
tag_i  in  TAG_W  opaque tag
out_valid_o  out  1  output entry valid
out_ready_i  in  1  downstream accepts
sign_A_o, sign_B_o  out  1 each  sign bits
exp_A_o, exp_B_o  out  8 each  raw exponents
sig_A_o, sig_B_o  out  23 each  raw fractions
isZeroA_o, isZeroB_o, isInfA_o, isInfB_o, isNaNA_o, isNaNB_o, isSubA_o, isSubB_o  out  1 each  class flags
isSignaling_o  out  1  either operand is sNaN
sub_op_o  out  1  registered sub_op_i
rounding_mode_o  out  3  resolved mode
rm_illegal_o  out  1  resolved mode is 101/110/111
exp_diff_o  out  8  |effA-effB|
swap_o  out  1  |B| > |A| (magnitude, ignoring sign)
tag_o  out  TAG_W  registered tag

Behaviour:
- Reset (reset_i=0, async): both skid entries invalid; out_valid_o=0; in_ready_o=1; all data outputs 0. Entries released by reset are lost.
- Transfer in on in_valid_i & in_ready_o; transfer out on out_valid_o & out_ready_i.
- Latency 1: op accepted at edge N is on outputs after edge N (out_valid_o=1) when stage was empty.
- Storage: main entry (drives outputs) + skid entry. in_ready_o = ~skid_valid (registered). If main full, not draining and input accepted -> goes to skid. When main drains, skid (if valid) moves to main the same edge; otherwise a simultaneously accepted input fills main. Order strictly FIFO; no bubble under continuous out_ready_i=1 (throughput 1/cycle).
- Simultaneous accept and drain with main full and skid empty: main takes new op, skid stays empty.
- Classification (computed combinationally at input, registered): Zero = exp==0 & frac==0; Sub = exp==0 & frac!=0; Inf = exp==255 & frac==0; NaN = exp==255 & frac!=0. sNaN = NaN & frac[22]==0. isSignaling = sNaN_A | sNaN_B. Exactly one of {Zero,Sub,Inf,NaN} or none (normal) per operand.
- Rounding: rm_i==3'b111 -> rounding_mode_o=frm_i, else rm_i. rm_illegal_o=1 if result in {101,110,111}; op still passes (downstream raises illegal).
- Alignment: effX = (expX==0) ? 1 : expX. swap_o = {expB,fracB} > {expA,fracA} (31-bit unsigned compare). exp_diff_o = swap_o ? effB-effA : effA-effB (8-bit, never negative). NaN/Inf operands computed identically; downstream fast path ignores them.
- flush_i=1: both entries invalidated at edge, in_ready_o=1 next cycle; input presented in the flush cycle is dropped (not accepted) regardless of in_valid_i.
- Data outputs hold last value while out_valid_o=0; stable while out_valid_o=1 & out_ready_i=0.

Test Plan:
- Reset then opA=0x3F800000, opB=0x40000000, rm_i=000, single op, out_ready_i=1 -> next cycle out_valid_o=1, all class flags 0, swap_o=1, exp_diff_o=1, rounding_mode_o=000.
- opA=0x7F800001 (sNaN), opB=0x00000000 -> isNaNA_o=1, isZeroB_o=1, isSignaling_o=1; opA=0x7FC00000 -> isSignaling_o=0.
- opA=0x00000001, opB=0x80800000 -> isSubA_o=1, swap_o=1, exp_diff_o=0 (eff exps 1,1); rm_i=111, frm_i=011 -> rounding_mode_o=011; frm_i=110 -> rm_illegal_o=1.
- Back-pressure: 3 ops back-to-back, out_ready_i=0 -> 2 held, in_ready_o=0 after second; third stalled; release -> tags emerge in order 1,2,3 on consecutive cycles, no loss or duplication.
- Streaming 16 ops with out_ready_i=1 constant -> 16 outputs on 16 consecutive cycles, in_ready_o never falls.
- Two entries held, assert flush_i with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, flushed-cycle op never appears; async reset mid-stream -> outputs 0 immediately.
